pattern_scan_ctrl: RTL and testbench

//  Run controller for serial bit-pattern detection. Latches a programmable pattern/length,

---
 rtl/pattern_scan_pkg.sv | 25 ++
 rtl/pattern_scan_ctrl_if.sv | 40 ++++
 rtl/pattern_match_core.sv | 62 ++++++
 rtl/pattern_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_scan_pkg.sv
//------------------------------------------------------------------------------
// pattern_scan_pkg : shared state encoding and length clamp for pattern_scan_ctrl
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pattern_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

  // A zero length means a single-bit pattern; over-long lengths saturate.
  function automatic int clamp_len(input int len, input int pat_w);
    if (len == 0) return 1;
    if (len > pat_w) return pat_w;
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pattern_scan_ctrl_if.sv
//------------------------------------------------------------------------------
// pattern_scan_ctrl_if : control, config, stream and status bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pattern_scan_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_max_hits;
  logic [TMO_W-1:0] cfg_timeout;
  logic             x_valid;
  logic             x;
  logic             busy;
  logic             hit;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_max_hits, cfg_timeout, x_valid, x,
    input  busy, hit, done, timed_out, hit_count
  );

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_max_hits, cfg_timeout, x_valid, x,
    output busy, hit, done, timed_out, hit_count
  );

endinterface

`default_nettype wire

// File: rtl/pattern_match_core.sv
//------------------------------------------------------------------------------
// pattern_match_core : history shifter, fill counter and masked pattern compare
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pattern_match_core #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             x,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             match_next
);

  logic [PAT_W-1:0] history_q, history_d;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] bits_seen_q, bits_seen_d;

  always_comb begin
    history_d   = history_q;
    bits_seen_d = bits_seen_q;
    if (clr) begin
      history_d   = '0;
      bits_seen_d = '0;
    end else if (shift_en) begin
      history_d = {history_q[PAT_W-2:0], x};
      if (bits_seen_q != LEN_W'(PAT_W)) begin
        bits_seen_d = bits_seen_q + LEN_W'(1);
      end
    end
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // Compare against the post-shift history so a hit can be registered on the accepting edge.
  assign match_next = shift_en && !clr && (bits_seen_d >= len) &&
                      ((history_d & mask) == (pattern & mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_q   <= '0;
      bits_seen_q <= '0;
    end else begin
      history_q   <= history_d;
      bits_seen_q <= bits_seen_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
//------------------------------------------------------------------------------
// pattern_scan_ctrl : run controller for serial pattern detection with hit quota/timeout
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pattern_scan_ctrl #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  parameter int TMO_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  pattern_scan_ctrl_if.slave  bus
);
  import pattern_scan_pkg::*;

  localparam int LEN_W = $clog2(PAT_W + 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] max_hits_q, max_hits_d;
  logic [TMO_W-1:0] timeout_q, timeout_d;
  logic [TMO_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic             busy_q, busy_d;
  logic             hit_q, hit_d;
  logic             done_q, done_d;
  logic             timed_out_q, timed_out_d;
  logic             core_clr;
  logic             shift_en;
  logic             match_next;

  assign core_clr = (state_q == ARM);
  assign shift_en = (state_q == SCAN) && bus.x_valid;

  pattern_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (core_clr),
    .shift_en   (shift_en),
    .x          (bus.x),
    .pattern    (pattern_q),
    .len        (len_q),
    .match_next (match_next)
  );

  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    max_hits_d  = max_hits_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q;
    hit_count_d = hit_count_q;
    timed_out_d = timed_out_q;
    hit_d       = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          pattern_d  = bus.cfg_pattern;
          len_d      = LEN_W'(clamp_len(int'(bus.cfg_len), PAT_W));
          max_hits_d = bus.cfg_max_hits;
          timeout_d  = bus.cfg_timeout;
          state_d    = ARM;
        end
      end
      ARM: begin
        timer_d     = '0;
        hit_count_d = '0;
        timed_out_d = 1'b0;
        state_d     = SCAN;
      end
      SCAN: begin
        timer_d = timer_q + TMO_W'(1);
        if (match_next) begin
          hit_d = 1'b1;
          if (hit_count_q != '1) begin
            hit_count_d = hit_count_q + CNT_W'(1);
          end
        end
        // Hit quota is checked first so it wins a same-edge tie with the timeout.
        if (match_next && (max_hits_q != '0) && (hit_count_d == max_hits_q)) begin
          state_d = DONE;
        end else if ((timeout_q != '0) && (timer_d == timeout_q)) begin
          state_d     = DONE;
          timed_out_d = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.abort) begin
      state_d     = IDLE;
      hit_d       = 1'b0;
      done_d      = 1'b0;
      hit_count_d = hit_count_q;
      timed_out_d = timed_out_q;
    end
  end

  assign busy_d = (state_d == ARM) || (state_d == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      max_hits_q  <= '0;
      timeout_q   <= '0;
      timer_q     <= '0;
      hit_count_q <= '0;
      busy_q      <= 1'b0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      max_hits_q  <= max_hits_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
      hit_count_q <= hit_count_d;
      busy_q      <= busy_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.hit       = hit_q;
  assign bus.done      = done_q;
  assign bus.timed_out = timed_out_q;
  assign bus.hit_count = hit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_scan_ctrl.sv
//------------------------------------------------------------------------------
// tb_pattern_scan_ctrl : directed and randomized runs checked against a bit-queue model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pattern_scan_ctrl;

  localparam int PAT_W = 8;
  localparam int MAXC  = 64;

  logic clk;
  logic rst_n;

  pattern_scan_ctrl_if #(.PAT_W(8), .CNT_W(8), .TMO_W(16)) bus ();

  pattern_scan_ctrl #(.PAT_W(8), .CNT_W(8), .TMO_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int fail_count;

  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_max;
  logic [15:0] cfg_tmo;
  bit          stim_v [MAXC];
  bit          stim_x [MAXC];
  // Packed view per cycle: {hit, busy, done, timed_out, hit_count[7:0]}
  logic [11:0] obs [MAXC+2];
  logic [11:0] expv [MAXC+2];

  function automatic int lclamp(input int l);
    if (l == 0) return 1;
    if (l > PAT_W) return PAT_W;
    return l;
  endfunction

  task automatic capture_run(input int n, input int abort_at);
    bus.cfg_pattern  = cfg_pat;
    bus.cfg_len      = cfg_len;
    bus.cfg_max_hits = cfg_max;
    bus.cfg_timeout  = cfg_tmo;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < n + 2; k++) begin
      bus.x_valid = (k < n) ? stim_v[k] : 1'b0;
      bus.x       = (k < n) ? stim_x[k] : 1'b0;
      bus.abort   = (k == abort_at);
      @(posedge clk); #1;
      obs[k] = {bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count};
    end
    bus.x_valid = 1'b0;
    bus.abort   = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(posedge clk); #1;
  endtask

  // Keeps the accepted bits in a queue and matches the newest len of them against the pattern.
  task automatic model_run(input int n, input int abort_at);
    bit q[$];
    int cnt, l, done_at;
    bit active, to, eh, m;
    cnt = 0; l = lclamp(int'(cfg_len)); done_at = -1; active = 1; to = 0;
    for (int k = 0; k < n + 2; k++) begin
      eh = 0;
      if (active) begin
        if (k == abort_at) begin
          active = 0;
        end else begin
          if (k < n && stim_v[k]) begin
            q.push_back(stim_x[k]);
            if (q.size() > PAT_W) void'(q.pop_front());
            m = (q.size() >= l);
            for (int i = 0; i < l; i++)
              if (m && q[q.size() - 1 - i] != cfg_pat[i]) m = 0;
            if (m) begin
              eh = 1;
              if (cnt < 255) cnt++;
            end
          end
          if (cfg_max != 0 && eh && cnt == int'(cfg_max)) begin
            active = 0; done_at = k + 1;
          end else if (cfg_tmo != 0 && k + 1 == int'(cfg_tmo)) begin
            active = 0; to = 1; done_at = k + 1;
          end
        end
      end
      expv[k] = {eh, active, (k == done_at), to, 8'(cnt)};
    end
  endtask

  task automatic load_stream(input string bits_s);
    for (int k = 0; k < bits_s.len(); k++) begin
      stim_v[k] = 1'b1;
      stim_x[k] = (bits_s[k] == "1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count} !== 12'h000) begin
      fail_count++;
      $display("FAIL reset_low got=%h exp=000", {bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count} !== 12'h000) begin
      fail_count++;
      $display("FAIL reset_idle got=%h exp=000", {bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count});
    end
  endtask

  task automatic test_overlap();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd0; cfg_tmo = 16'd0;
    load_stream("1101101");
    capture_run(7, -1);
    model_run(7, -1);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL overlap k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[3][11], obs[6][11], obs[8][7:0]} !== {1'b1, 1'b1, 8'd2}) begin
      fail_count++;
      $display("FAIL overlap_hits got=%b%b cnt=%0d exp=11 cnt=2", obs[3][11], obs[6][11], obs[8][7:0]);
    end
  endtask

  task automatic test_quota();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd2; cfg_tmo = 16'd0;
    load_stream("1101101");
    capture_run(7, -1);
    model_run(7, -1);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL quota k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[6][10], obs[7][9], obs[7][8], obs[7][7:0]} !== {1'b0, 1'b1, 1'b0, 8'd2}) begin
      fail_count++;
      $display("FAIL quota_done got=%h/%h exp busy0 then done1 to0 cnt2", obs[6], obs[7]);
    end
  endtask

  task automatic test_timeout();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd0; cfg_tmo = 16'd10;
    for (int k = 0; k < 12; k++) begin stim_v[k] = 1'b1; stim_x[k] = 1'b0; end
    capture_run(12, -1);
    model_run(12, -1);
    for (int k = 0; k < 14; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL timeout k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[8][10], obs[10][9], obs[10][8]} !== 3'b111) begin
      fail_count++;
      $display("FAIL timeout_done got=%h/%h exp busy@8 done+to@10", obs[8], obs[10]);
    end
  endtask

  task automatic test_gaps();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd0; cfg_tmo = 16'd0;
    for (int k = 0; k < 8; k++) begin
      stim_v[k] = (k % 2 == 0);
      stim_x[k] = 1'($urandom_range(0, 1));
    end
    stim_x[0] = 1'b1; stim_x[2] = 1'b1; stim_x[4] = 1'b0; stim_x[6] = 1'b1;
    capture_run(8, -1);
    model_run(8, -1);
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL gaps k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[6][11], obs[9][7:0]} !== {1'b1, 8'd1}) begin
      fail_count++;
      $display("FAIL gaps_single_hit got hit6=%b cnt=%0d exp 1/1", obs[6][11], obs[9][7:0]);
    end
  endtask

  task automatic test_quota_vs_timeout();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd1; cfg_tmo = 16'd4;
    load_stream("1101");
    capture_run(4, -1);
    model_run(4, -1);
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL tie k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[4][9], obs[4][8], obs[4][7:0]} !== {1'b1, 1'b0, 8'd1}) begin
      fail_count++;
      $display("FAIL tie_quota_wins got=%h exp done1 to0 cnt1", obs[4]);
    end
  endtask

  task automatic test_abort();
    cfg_pat = 8'h0D; cfg_len = 4'd4; cfg_max = 8'd0; cfg_tmo = 16'd0;
    load_stream("1101101");
    capture_run(7, 5);
    model_run(7, 5);
    for (int k = 0; k < 9; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL abort k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if ({obs[5][10], obs[6][9], obs[8][7:0]} !== {1'b0, 1'b0, 8'd1}) begin
      fail_count++;
      $display("FAIL abort_hold got=%h/%h/%h exp idle, no done, cnt1", obs[5], obs[6], obs[8]);
    end
  endtask

  task automatic test_reset_mid();
    bus.cfg_pattern = 8'h01; bus.cfg_len = 4'd1; bus.cfg_max_hits = 8'd0; bus.cfg_timeout = 16'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x_valid = 1'b1; bus.x = 1'b1;
    repeat (4) @(posedge clk); #1;
    tests_run++;
    if ({bus.hit, bus.busy, bus.hit_count} !== {1'b1, 1'b1, 8'd3}) begin
      fail_count++;
      $display("FAIL rst_mid_pre got hit=%b busy=%b cnt=%0d exp 1/1/3", bus.hit, bus.busy, bus.hit_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count} !== 12'h000) begin
      fail_count++;
      $display("FAIL rst_mid got=%h exp=000", {bus.hit, bus.busy, bus.done, bus.timed_out, bus.hit_count});
    end
    #2 rst_n = 1'b1;
    bus.x_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({bus.hit, bus.busy, bus.hit_count} !== 10'h000) begin
      fail_count++;
      $display("FAIL rst_mid_after got hit=%b busy=%b cnt=%0d exp idle", bus.hit, bus.busy, bus.hit_count);
    end
  endtask

  task automatic test_len_clamp();
    cfg_pat = 8'($urandom) | 8'h01; cfg_len = 4'd0; cfg_max = 8'd0; cfg_tmo = 16'd0;
    for (int k = 0; k < 16; k++) begin
      stim_v[k] = 1'($urandom_range(0, 1));
      stim_x[k] = 1'($urandom_range(0, 1));
    end
    capture_run(16, -1);
    model_run(16, -1);
    for (int k = 0; k < 18; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL len0 k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    cfg_pat = 8'($urandom); cfg_len = 4'd15; cfg_tmo = 16'd0;
    for (int k = 0; k < 20; k++) begin
      stim_v[k] = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      stim_x[k] = (k < 8) ? cfg_pat[7 - k] : 1'($urandom_range(0, 1));
    end
    capture_run(20, -1);
    model_run(20, -1);
    for (int k = 0; k < 22; k++) begin
      tests_run++;
      if (obs[k] !== expv[k]) begin
        fail_count++;
        $display("FAIL len15 k=%0d got=%h exp=%h", k, obs[k], expv[k]);
      end
    end
    tests_run++;
    if (obs[7][11] !== 1'b1) begin
      fail_count++;
      $display("FAIL len15_first_hit got=%b exp=1", obs[7][11]);
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 12; it++) begin
      cfg_pat = 8'($urandom);
      cfg_len = 4'($urandom_range(0, 5));
      if (it % 4 == 3) cfg_len = 4'($urandom_range(6, 15));
      cfg_max = 8'($urandom_range(0, 3));
      cfg_tmo = (it % 3 == 0) ? 16'd0 : 16'($urandom_range(5, 40));
      n = 40;
      for (int k = 0; k < n; k++) begin
        stim_v[k] = ($urandom_range(0, 3) != 0);
        stim_x[k] = 1'($urandom_range(0, 1));
      end
      capture_run(n, (it == 5) ? 12 : -1);
      model_run(n, (it == 5) ? 12 : -1);
      for (int k = 0; k < n + 2; k++) begin
        tests_run++;
        if (obs[k] !== expv[k]) begin
          fail_count++;
          $display("FAIL random it=%0d k=%0d pat=%h len=%0d max=%0d tmo=%0d got=%h exp=%h",
                   it, k, cfg_pat, cfg_len, cfg_max, cfg_tmo, obs[k], expv[k]);
        end
      end
    end
  endtask

  initial begin
    tests_run  = 0;
    fail_count = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.x_valid = 1'b0; bus.x = 1'b0;
    bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_max_hits = '0; bus.cfg_timeout = '0;
    @(posedge clk); #1;
    test_reset();
    test_overlap();
    test_quota();
    test_timeout();
    test_gaps();
    test_quota_vs_timeout();
    test_abort();
    test_reset_mid();
    test_len_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule

`default_nettype wire
